seat_query_responder: RTL
=========================

# seat_query_responder

Read-side companion to the seating controller's commit interface. It snoops every committed seat update (seat, student, state, time) into a shadow table and serves queries from a host or display over a valid/ready request and response pair. A query returns either one seat's record or a streamed scan of all non-empty seats, each with elapsed time since that seat's last state change.

## Interface
Parameters:
- NUM_SEATS, 8, number of seats tracked (indices 0..NUM_SEATS-1)
- SEAT_W, 5, seat index width
- ID_W, 32, student number width
- TIME_W, 11, time/counter width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cm_valid  in  1  commit strobe from seating controller, one cycle per update
- cm_seat_no  in  SEAT_W  seat being updated
- cm_student_no  in  ID_W  student owning the update
- cm_seat_state  in  2  0 empty, 1 away, 2 occupied, 3 reserved/illegal
- cur_time  in  TIME_W  free-running system time
- q_valid  in  1  query request
- q_ready  out  1  responder can accept a query
- q_mode  in  1  0 single-seat, 1 scan
- q_seat_no  in  SEAT_W  seat for single-seat query
- r_valid  out  1  response record valid
- r_ready  in  1  consumer accepts record
- r_seat_no  out  SEAT_W  record seat index
- r_state  out  2  record state; 3 means invalid/terminator
- r_student_no  out  ID_W  record owner, 0 when empty/invalid
- r_elapsed  out  TIME_W  cur_time minus stamp, at capture
- r_last  out  1  final record of this query

## Operation
- Shadow table per seat: state (2b), student (ID_W), stamp (TIME_W). Reset: all 0.
- Commit with cm_valid=1, cm_seat_no<NUM_SEATS, cm_seat_state in {0,1,2}: state<=cm_seat_state, stamp<=cur_time; student<=cm_student_no, or 0 if state 0. Other commits are ignored.
- Elapsed = (cur_time - stamp) mod 2^TIME_W. Wrap is intentional; no saturation.
- FSM states: IDLE, SINGLE, SCAN, OUT, TERM.
  - IDLE: q_ready=1. On q_valid: mode 0 goes to SINGLE, mode 1 goes to SCAN with idx=0.
  - SINGLE: holds the record loaded at accept. If q_seat_no>=NUM_SEATS the record is {seat=q_seat_no, state=3, student 0, elapsed 0}. r_last=1. On r handshake, go to IDLE.
  - SCAN: examine seat idx once per cycle.
    - Non-empty seat: load record, go to OUT.
    - Empty seat with idx=NUM_SEATS-1: load terminator, go to TERM.
    - Otherwise idx+1.
  - OUT: r_last=0. On handshake: if idx=NUM_SEATS-1, load terminator and go to TERM; else idx+1 and go to SCAN.
  - TERM: terminator record {seat all-ones, state 3, student 0, elapsed 0, r_last=1}. On handshake, go to IDLE.
- A record is captured at load and held stable while r_valid=1 && r_ready=0.
- Commit in the same cycle as a record load: the record gets the pre-commit table value. The table still updates.
- Commit during scan to a seat not yet examined is visible when that seat is examined.

## Timing
- Reset values: q_ready=1, r_valid=0, r_seat_no=0, r_state=0, r_student_no=0, r_elapsed=0, r_last=0; FSM=IDLE, idx=0.
- rst asserted mid-query aborts: r_valid drops asynchronously, table clears.
- Commit written at edge E; visible to record loads from E onward, i.e. to any load evaluated in the cycle after E.
- Single query accepted at edge T: r_valid=1 after T. The response handshake completes at some edge H; q_ready=1 after H, and r_valid=0 after H.
- Scan accepted at edge T: seat 0 examined in the cycle after T. An occupied seat 0 gives r_valid after edge T+1. Each skipped empty seat adds 1 cycle.
- Back-to-back records with r_ready held at 1: one record per 2 cycles (OUT to SCAN to OUT).
- r_valid is never high in IDLE or SCAN. q_ready=0 in every non-IDLE state.

## Test plan
- Reset, then commit seat 1, student 201819186, state 2 at cur_time=10. At cur_time=25, single query seat 1 -> state 2, student 201819186, elapsed 15, r_last=1.
- Commit seat 2 state 2, then state 1, then state 0. Single query seat 2 -> state 0, student 0. Query seat 9 -> state 3, r_last=1.
- Seats 1, 2 and 5 occupied; scan with r_ready=1 -> records for seats 1, 2, 5 (r_last=0), then terminator with r_last=1. Empty table -> terminator only, after NUM_SEATS+1 cycles.
- Stamp 2040, cur_time wraps to 5 -> elapsed 13.
- Scan with r_ready low for 4 cycles on the seat 2 record, plus a commit clearing seat 2 in the load cycle -> record stays stable with the old data; table shows seat 2 empty afterwards.
- rst pulsed mid-scan -> r_valid=0 immediately, q_ready=1, all seats read back state 0.

Source files
------------

// File: rtl/seat_query_responder.sv
`default_nettype none
// ============================================================================
// Module  : seat_query_responder
// Brief   : Shadows seat commits and answers single-seat or scan queries.
// Rev     : 1.0  initial release
// ============================================================================
module seat_query_responder #(
    parameter int NUM_SEATS = 8,
    parameter int SEAT_W    = 5,
    parameter int ID_W      = 32,
    parameter int TIME_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cm_valid,
    input  logic [SEAT_W-1:0] cm_seat_no,
    input  logic [ID_W-1:0]   cm_student_no,
    input  logic [1:0]        cm_seat_state,
    input  logic [TIME_W-1:0] cur_time,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic              q_mode,
    input  logic [SEAT_W-1:0] q_seat_no,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [SEAT_W-1:0] r_seat_no,
    output logic [1:0]        r_state,
    output logic [ID_W-1:0]   r_student_no,
    output logic [TIME_W-1:0] r_elapsed,
    output logic              r_last
);

    localparam int                c_IDX_W = (NUM_SEATS > 1) ? $clog2(NUM_SEATS) : 1;
    localparam logic [SEAT_W-1:0] c_LAST  = SEAT_W'(NUM_SEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SINGLE = 3'd1,
        S_SCAN   = 3'd2,
        S_OUT    = 3'd3,
        S_TERM   = 3'd4
    } state_t;

    state_t            r_fsm;
    logic [SEAT_W-1:0] r_idx;
    logic              r_q_ready;
    logic              r_rsp_valid;
    logic [SEAT_W-1:0] r_rsp_seat;
    logic [1:0]        r_rsp_state;
    logic [ID_W-1:0]   r_rsp_student;
    logic [TIME_W-1:0] r_rsp_elapsed;
    logic              r_rsp_last;

    logic [1:0]        r_tbl_state   [NUM_SEATS];
    logic [ID_W-1:0]   r_tbl_student [NUM_SEATS];
    logic [TIME_W-1:0] r_tbl_stamp   [NUM_SEATS];

    logic               w_cm_ok;
    logic [c_IDX_W-1:0] w_cm_sel;
    logic               w_q_in;
    logic [c_IDX_W-1:0] w_q_sel;
    logic [1:0]         w_sg_state;
    logic [ID_W-1:0]    w_sg_student;
    logic [TIME_W-1:0]  w_sg_elapsed;
    logic [c_IDX_W-1:0] w_sc_sel;
    logic [1:0]         w_sc_state;
    logic [ID_W-1:0]    w_sc_student;
    logic [TIME_W-1:0]  w_sc_elapsed;
    logic               w_at_last;
    logic               w_hs;

    assign w_cm_ok  = cm_valid && (cm_seat_no <= c_LAST) && (cm_seat_state != 2'd3);
    assign w_cm_sel = cm_seat_no[c_IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEATS; i++) begin
                r_tbl_state[i]   <= '0;
                r_tbl_student[i] <= '0;
                r_tbl_stamp[i]   <= '0;
            end
        end else if (w_cm_ok) begin
            r_tbl_state[w_cm_sel]   <= cm_seat_state;
            r_tbl_student[w_cm_sel] <= (cm_seat_state == 2'd0) ? '0 : cm_student_no;
            r_tbl_stamp[w_cm_sel]   <= cur_time;
        end
    end

    // Lookups read the registered table, so a same-cycle commit is not seen.
    assign w_q_in       = (q_seat_no <= c_LAST);
    assign w_q_sel      = q_seat_no[c_IDX_W-1:0];
    assign w_sg_state   = w_q_in ? r_tbl_state[w_q_sel] : 2'd3;
    assign w_sg_student = w_q_in ? r_tbl_student[w_q_sel] : '0;
    assign w_sg_elapsed = w_q_in ? (cur_time - r_tbl_stamp[w_q_sel]) : '0;

    assign w_sc_sel     = r_idx[c_IDX_W-1:0];
    assign w_sc_state   = r_tbl_state[w_sc_sel];
    assign w_sc_student = r_tbl_student[w_sc_sel];
    assign w_sc_elapsed = cur_time - r_tbl_stamp[w_sc_sel];

    assign w_at_last = (r_idx == c_LAST);
    assign w_hs      = r_rsp_valid && r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm         <= S_IDLE;
            r_idx         <= '0;
            r_q_ready     <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_seat    <= '0;
            r_rsp_state   <= '0;
            r_rsp_student <= '0;
            r_rsp_elapsed <= '0;
            r_rsp_last    <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (q_valid) begin
                        r_q_ready <= 1'b0;
                        if (!q_mode) begin
                            r_fsm         <= S_SINGLE;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_seat    <= q_seat_no;
                            r_rsp_state   <= w_sg_state;
                            r_rsp_student <= w_sg_student;
                            r_rsp_elapsed <= w_sg_elapsed;
                            r_rsp_last    <= 1'b1;
                        end else begin
                            r_fsm <= S_SCAN;
                            r_idx <= '0;
                        end
                    end
                end
                S_SINGLE: begin
                    if (w_hs) begin
                        r_fsm       <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_q_ready   <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_sc_state != 2'd0) begin
                        r_fsm         <= S_OUT;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_seat    <= r_idx;
                        r_rsp_state   <= w_sc_state;
                        r_rsp_student <= w_sc_student;
                        r_rsp_elapsed <= w_sc_elapsed;
                        r_rsp_last    <= 1'b0;
                    end else if (w_at_last) begin
                        r_fsm         <= S_TERM;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_seat    <= '1;
                        r_rsp_state   <= 2'd3;
                        r_rsp_student <= '0;
                        r_rsp_elapsed <= '0;
                        r_rsp_last    <= 1'b1;
                    end else begin
                        r_idx <= r_idx + SEAT_W'(1);
                    end
                end
                S_OUT: begin
                    if (w_hs) begin
                        if (w_at_last) begin
                            r_fsm         <= S_TERM;
                            r_rsp_seat    <= '1;
                            r_rsp_state   <= 2'd3;
                            r_rsp_student <= '0;
                            r_rsp_elapsed <= '0;
                            r_rsp_last    <= 1'b1;
                        end else begin
                            r_fsm       <= S_SCAN;
                            r_idx       <= r_idx + SEAT_W'(1);
                            r_rsp_valid <= 1'b0;
                        end
                    end
                end
                S_TERM: begin
                    if (w_hs) begin
                        r_fsm       <= S_IDLE;
                        r_idx       <= '0;
                        r_rsp_valid <= 1'b0;
                        r_q_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_fsm       <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_q_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign q_ready      = r_q_ready;
    assign r_valid      = r_rsp_valid;
    assign r_seat_no    = r_rsp_seat;
    assign r_state      = r_rsp_state;
    assign r_student_no = r_rsp_student;
    assign r_elapsed    = r_rsp_elapsed;
    assign r_last       = r_rsp_last;

endmodule
`default_nettype wire
